// File: rtl/cp0_random.sv
// cp0_random: CP0 Random register (reg 1), the replacement index source for tlbwr
module cp0_random #(
    parameter int ENTRIES = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wired_we,
    input  logic [31:0]      wired_q,
    input  logic             tlbwr,
    output logic [31:0]      random_q,
    output logic             tlbwr_ack,
    output logic [IDX_W-1:0] tlbwr_index
);
    localparam logic [IDX_W-1:0] TOP = IDX_W'(ENTRIES - 1);
    logic [IDX_W-1:0] rnd_q, rnd_d, idx_q, idx_d;
    logic ack_q, ack_d;
    logic [4:0] w;
    logic wrap;
    logic unused_wired;
    assign unused_wired = ^wired_q[31:4];
    assign w = {1'b0, wired_q[3:0]};
    assign wrap = (w >= 5'(ENTRIES)) || (5'(rnd_q) <= w);
    // Wired write reloads even when stalled; tlbwr captures the pre-update Random
    always_comb begin
        rnd_d = wired_we ? TOP : !en ? rnd_q : wrap ? TOP : rnd_q - 1'b1;
        ack_d = en && tlbwr;
        idx_d = ack_d ? rnd_q : idx_q;
    end
    // State registers, asynchronously reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_q <= TOP;
            ack_q <= 1'b0;
            idx_q <= '0;
        end else begin
            rnd_q <= rnd_d;
            ack_q <= ack_d;
            idx_q <= idx_d;
        end
    end
    assign random_q = {{(32-IDX_W){1'b0}}, rnd_q};
    assign tlbwr_ack = ack_q;
    assign tlbwr_index = idx_q;
endmodule

// File: tb/tb_cp0_random.sv
// tb_cp0_random: directed scoreboard bench for cp0_random
module tb_cp0_random;
    logic clk = 1'b0;
    logic rst, en, wired_we, tlbwr;
    logic [31:0] wired_q, random_q;
    logic tlbwr_ack;
    logic [3:0] tlbwr_index;
    int tests = 0;
    int fails = 0;
    int m_rand, m_idx, wreg;
    typedef struct {
        int rnd;
        int ack;
        int idx;
    } exp_t;
    exp_t sb[$];

    cp0_random dut (
        .clk(clk), .rst(rst), .en(en), .wired_we(wired_we), .wired_q(wired_q),
        .tlbwr(tlbwr), .random_q(random_q), .tlbwr_ack(tlbwr_ack), .tlbwr_index(tlbwr_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push the model's prediction, compare after the edge
    task automatic step(input logic e, input logic we, input logic [3:0] wd, input logic t);
        exp_t x;
        en = e;
        wired_we = we;
        tlbwr = t;
        x.ack = (e && t) ? 1 : 0;
        x.idx = x.ack ? m_rand : m_idx;
        x.rnd = we ? 15 : !e ? m_rand : (m_rand <= wreg) ? 15 : m_rand - 1;
        sb.push_back(x);
        m_rand = x.rnd;
        m_idx = x.idx;
        @(posedge clk);
        #1;
        if (we) begin
            wreg = int'(wd);
            wired_q = {28'b0, wd};
        end
        en = 1'b0;
        wired_we = 1'b0;
        tlbwr = 1'b0;
        @(negedge clk);
        if (sb.size() == 0) chk("sb_underflow", 0, 1);
        else begin
            x = sb.pop_front();
            chk("random_q", int'(random_q), x.rnd);
            chk("tlbwr_ack", int'(tlbwr_ack), x.ack);
            chk("tlbwr_index", int'(tlbwr_index), x.idx);
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        wired_we = 1'b0;
        tlbwr = 1'b0;
        wired_q = 32'd0;
        wreg = 0;
        m_rand = 15;
        m_idx = 0;
        #2;
        chk("reset_random", int'(random_q), 15);
        chk("reset_ack", int'(tlbwr_ack), 0);
        chk("reset_index", int'(tlbwr_index), 0);
        #10;
        rst = 1'b0;
        // full sweep with W=0
        for (int i = 0; i < 18; i++) step(1, 0, 0, 0);
        // reach 9, then write Wired=4
        for (int i = 0; i < 20 && m_rand != 9; i++) step(1, 0, 0, 0);
        chk("t2_at9", int'(random_q), 9);
        step(1, 1, 4, 0);
        chk("t2_reload", int'(random_q), 15);
        for (int i = 0; i < 14; i++) begin
            step(1, 0, 0, 0);
            chk("t2_floor", int'(random_q >= 4), 1);
        end
        // stall sequence from 12
        for (int i = 0; i < 20 && m_rand != 12; i++) step(1, 0, 0, 0);
        chk("t3_at12", int'(random_q), 12);
        step(1, 0, 0, 0);
        chk("t3_11", int'(random_q), 11);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("t3_stall_tlbwr_ignored", int'(tlbwr_ack), 0);
        step(1, 0, 0, 0);
        chk("t3_10", int'(random_q), 10);
        step(0, 1, 4, 0);
        chk("t3_stall_reload", int'(random_q), 15);
        // tlbwr at the wrap point with W=2
        step(1, 1, 2, 0);
        for (int i = 0; i < 20 && m_rand != 2; i++) step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        chk("t4_ack", int'(tlbwr_ack), 1);
        chk("t4_index", int'(tlbwr_index), 2);
        chk("t4_random", int'(random_q), 15);
        step(1, 0, 0, 0);
        chk("t4_ack_drop", int'(tlbwr_ack), 0);
        chk("t4_index_hold", int'(tlbwr_index), 2);
        // simultaneous tlbwr and Wired write
        for (int i = 0; i < 20 && m_rand != 6; i++) step(1, 0, 0, 0);
        step(1, 1, 8, 1);
        chk("t5_index", int'(tlbwr_index), 6);
        chk("t5_ack", int'(tlbwr_ack), 1);
        chk("t5_random", int'(random_q), 15);
        chk("t5_wired", int'(wired_q), 8);
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0, 0);
            chk("t5_floor", int'(random_q >= 8), 1);
        end
        // Wired=15 pins Random
        step(1, 1, 15, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0);
            chk("t6_pinned", int'(random_q), 15);
        end
        step(1, 0, 0, 1);
        chk("t6_ack_pre", int'(tlbwr_ack), 1);
        // async reset mid-cycle during tlbwr
        en = 1'b1;
        tlbwr = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_ack", int'(tlbwr_ack), 0);
        chk("t6_async_index", int'(tlbwr_index), 0);
        chk("t6_async_random", int'(random_q), 15);
        en = 1'b0;
        tlbwr = 1'b0;
        wired_q = 32'd0;
        wreg = 0;
        m_rand = 15;
        m_idx = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        // back-to-back tlbwr after reset
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1);
            chk("t7_b2b_ack", int'(tlbwr_ack), 1);
            chk("t7_b2b_index", int'(tlbwr_index), 15 - i);
        end
        step(1, 0, 0, 0);
        chk("t7_ack_end", int'(tlbwr_ack), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
